// File: rtl/phase_fold_nco_pkg.sv
// Shared types and constants for the phase generator and the sine stage it feeds.
package phase_fold_nco_pkg;

   // Sequencer states of the phase generator.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Quarter turn of an n-bit phase word: the folded value that maps to argument +1.0.
   function automatic int quarter_turn(input int n);
      return 1 << (n - 2);
   endfunction

   // Largest positive w-bit two's complement value; +1.0 saturates here.
   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

endpackage

// File: rtl/phase_fold_nco_if.sv
// Sample stream from the phase generator to the sine stage (valid/ready with last tag).
interface phase_fold_nco_if #(
   parameter int W = 16
) ();
   logic signed [W-1:0] dout;
   logic                dout_valid;
   logic                dout_ready;
   logic                dout_last;

   modport master (output dout, output dout_valid, output dout_last, input dout_ready);
   modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/phase_fold_nco_fold.sv
// Folds a full-circle phase into [-1,1) (full scale = +/-pi/2) so that
// sin(pi/2 * dout) equals sin(2*pi * phase / 2^N). Purely combinational.
// W must not exceed N.
module phase_quadrant_fold
   import phase_fold_nco_pkg::*;
#(
   parameter int N = 16,
   parameter int W = 16
) (
   input  logic [N-1:0] ps,
   output logic [W-1:0] dout
);

   // Two guard bits keep the reflections and the doubling free of overflow.
   localparam logic signed [N+1:0] QUARTER = (N+2)'(quarter_turn(N));
   localparam logic signed [N+1:0] HALF    = QUARTER <<< 1;
   localparam logic [W-1:0]        SAT     = W'(sat_max(W));

   logic signed [N+1:0] p_ext;
   logic signed [N+1:0] p_fold;
   logic signed [N+1:0] p_twice;
   logic signed [N+1:0] p_scaled;

   // Reflect the outer half-circle about +/-pi/2, then rescale to W bits.
   always_comb begin
      p_ext = {{2{ps[N-1]}}, ps};
      if (p_ext >= QUARTER) begin
         p_fold = HALF - p_ext;
      end else if (p_ext < -QUARTER) begin
         p_fold = -HALF - p_ext;
      end else begin
         p_fold = p_ext;
      end
      // P' * 2^(W-N+1) written as (2*P') >>> (N-W); arithmetic shift truncates LSBs.
      p_twice  = p_fold <<< 1;
      p_scaled = p_twice >>> (N - W);
      // +1.0 is not representable; it is the only value that can overflow.
      dout = (p_fold == QUARTER) ? SAT : W'(p_scaled);
   end

endmodule

// File: rtl/phase_fold_nco.sv
// Programmable phase accumulator with offset and quadrant fold, emitting
// burst or continuous samples on a valid/ready stream.
module phase_fold_nco
   import phase_fold_nco_pkg::*;
#(
   parameter int G_PHASE_WIDTH = 16,
   parameter int G_DOUT_WIDTH  = 16,
   parameter int G_COUNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [G_PHASE_WIDTH-1:0] freq_word,
   input  logic [G_PHASE_WIDTH-1:0] phase_offset,
   input  logic                     cfg_load,
   input  logic                     start,
   input  logic                     stop,
   input  logic [G_COUNT_WIDTH-1:0] num_samples,
   output logic                     busy,
   output logic                     done,
   phase_fold_nco_if.master         dout_if
);

   localparam int N = G_PHASE_WIDTH;
   localparam int W = G_DOUT_WIDTH;
   localparam logic [G_COUNT_WIDTH-1:0] CNT_ONE = G_COUNT_WIDTH'(1);

   state_t state_reg, state_next;
   logic   done_reg, done_next;

   logic [N-1:0]             acc_reg;
   logic [N-1:0]             freq_reg;
   logic [N-1:0]             off_reg;
   logic [G_COUNT_WIDTH-1:0] remaining_reg;
   logic                     cont_reg;

   logic         s1_valid_reg;
   logic         s1_last_reg;
   logic [N-1:0] s1_ps_reg;

   logic         out_valid_reg;
   logic         out_last_reg;
   logic [W-1:0] out_data_reg;
   logic [W-1:0] fold_out;

   logic clr;
   logic advance;
   logic stop_cont;
   logic issue;
   logic issue_last;

   // enable low behaves exactly like reset.
   assign clr        = reset || !enable;
   assign advance    = !out_valid_reg || dout_if.dout_ready;
   assign stop_cont  = (state_reg == RUN) && cont_reg && stop;
   assign issue      = (state_reg == RUN) && advance && !stop_cont;
   assign issue_last = issue && !cont_reg && (remaining_reg == CNT_ONE);

   // Sequencer next state and the done pulse raised when the pipeline empties in DRAIN.
   always_comb begin
      state_next = state_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (stop_cont || issue_last) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!s1_valid_reg && advance) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg <= IDLE;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
      end
   end

   // Configuration, accumulator and burst counter; config is taken only while idle.
   always_ff @(posedge clk) begin
      if (clr) begin
         acc_reg       <= '0;
         freq_reg      <= '0;
         off_reg       <= '0;
         remaining_reg <= '0;
         cont_reg      <= 1'b0;
      end else begin
         if (state_reg == IDLE && cfg_load) begin
            freq_reg <= freq_word;
            off_reg  <= phase_offset;
            acc_reg  <= '0;
         end
         if (state_reg == IDLE && start) begin
            remaining_reg <= num_samples;
            cont_reg      <= (num_samples == '0);
         end
         if (issue) begin
            acc_reg <= acc_reg + freq_reg;
            if (!cont_reg) begin
               remaining_reg <= remaining_reg - CNT_ONE;
            end
         end
      end
   end

   phase_quadrant_fold #(
      .N (N),
      .W (W)
   ) u_fold (
      .ps   (s1_ps_reg),
      .dout (fold_out)
   );

   // Two-stage pipeline (offset add, then fold); every stage holds while stalled.
   always_ff @(posedge clk) begin
      if (clr) begin
         s1_valid_reg  <= 1'b0;
         s1_last_reg   <= 1'b0;
         s1_ps_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         out_data_reg  <= '0;
      end else if (advance) begin
         s1_valid_reg  <= issue;
         s1_last_reg   <= issue_last;
         s1_ps_reg     <= acc_reg + off_reg;
         out_valid_reg <= s1_valid_reg;
         out_last_reg  <= s1_last_reg;
         out_data_reg  <= fold_out;
      end
   end

   assign busy               = (state_reg != IDLE);
   assign done               = done_reg;
   assign dout_if.dout       = out_data_reg;
   assign dout_if.dout_valid = out_valid_reg;
   assign dout_if.dout_last  = out_last_reg;

endmodule

// File: tb/tb_phase_fold_nco.sv
// Scoreboard bench: stimulus pushes model samples, a negedge monitor checks accepts.
module tb_phase_fold_nco;

   typedef struct packed {
      logic [15:0] d;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] freq_word;
   logic [15:0] phase_offset;
   logic        cfg_load;
   logic        start;
   logic        stop;
   logic [15:0] num_samples;
   logic        busy;
   logic        done;

   phase_fold_nco_if #(.W(16)) dif ();

   phase_fold_nco #(
      .G_PHASE_WIDTH (16),
      .G_DOUT_WIDTH  (16),
      .G_COUNT_WIDTH (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .freq_word    (freq_word),
      .phase_offset (phase_offset),
      .cfg_load     (cfg_load),
      .start        (start),
      .stop         (stop),
      .num_samples  (num_samples),
      .busy         (busy),
      .done         (done),
      .dout_if      (dif)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   int   accepted = 0;
   int   done_cnt = 0;
   bit   mon_en = 1'b1;
   int   rdy_mode = 0;     // 0: always, 1: 1,0,0 pattern, 2: random, 3: never

   logic [15:0] m_acc = '0;
   logic [15:0] m_freq = '0;
   logic [15:0] m_off = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
   endtask

   // sin(2*pi*phase/2^16) == sin(pi/2 * x): pick x in [-1,1] by reflecting about +/-90 deg.
   function automatic logic [15:0] model(input logic [15:0] phase);
      int p;
      int q;
      int r;
      p = int'(phase);
      if (p >= 32768) p = p - 65536;
      if (p >= 16384)       q = 32768 - p;
      else if (p < -16384)  q = -32768 - p;
      else                  q = p;
      r = q * 2;
      if (r > 32767) r = 32767;
      return r[15:0];
   endfunction

   function automatic logic [15:0] next_phase();
      logic [15:0] ph;
      ph    = m_off + m_acc;
      m_acc = m_acc + m_freq;
      return ph;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Downstream ready driver.
   initial begin
      int k;
      k = 0;
      dif.dout_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       dif.dout_ready = 1'b1;
            1:       dif.dout_ready = (k % 3 == 0);
            2:       dif.dout_ready = ($urandom_range(0, 3) != 0);
            default: dif.dout_ready = 1'b0;
         endcase
         k++;
      end
   end

   // Monitor: pops the scoreboard on each accepted sample, checks stall hold and done timing.
   logic [15:0] held;
   bit          hold_pending = 1'b0;
   bit          exp_done = 1'b0;
   exp_t        mon_e;
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_done) begin
            chk("done_after_last", {31'd0, done}, 32'd1);
            chk("busy_low_at_done", {31'd0, busy}, 32'd0);
            exp_done = 1'b0;
         end
         if (hold_pending) begin
            chk("stall_valid_held", {31'd0, dif.dout_valid}, 32'd1);
            chk("stall_dout_held", {16'd0, dif.dout}, {16'd0, held});
            hold_pending = 1'b0;
         end
         if (done) done_cnt++;
         if (dif.dout_valid && dif.dout_ready) begin
            accepted++;
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_sample: got %h expected none", dif.dout);
            end else begin
               mon_e = sb.pop_front();
               chk("dout", {16'd0, dif.dout}, {16'd0, mon_e.d});
               chk("dout_last", {31'd0, dif.dout_last}, {31'd0, mon_e.last});
               if (mon_e.last) exp_done = 1'b1;
            end
         end else if (dif.dout_valid) begin
            hold_pending = 1'b1;
            held = dif.dout;
         end
      end else begin
         hold_pending = 1'b0;
         exp_done = 1'b0;
      end
   end

   task automatic do_cfg(input logic [15:0] f, input logic [15:0] o);
      freq_word = f;
      phase_offset = o;
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      m_freq = f;
      m_off = o;
      m_acc = '0;
   endtask

   task automatic run_burst(input int n, input bit chk_lat, input bit poke,
                            input bit with_cfg, input logic [15:0] f, input logic [15:0] o);
      int d0;
      int lat;
      int t;
      if (with_cfg) begin
         freq_word = f;
         phase_offset = o;
         cfg_load = 1'b1;
         m_freq = f;
         m_off = o;
         m_acc = '0;
      end
      for (int k = 0; k < n; k++) sb.push_back('{d: model(next_phase()), last: (k == n - 1)});
      d0 = done_cnt;
      start = 1'b1;
      num_samples = 16'(n);
      step();
      start = 1'b0;
      cfg_load = 1'b0;
      if (chk_lat) begin
         lat = 1;
         while (!dif.dout_valid && lat < 10) begin
            step();
            lat++;
         end
         chk("first_latency", 32'(lat), 32'd3);
      end
      if (poke) begin
         freq_word = 16'h0123;
         phase_offset = 16'h4321;
         cfg_load = 1'b1;
         start = 1'b1;
         step();
         cfg_load = 1'b0;
         start = 1'b0;
      end
      t = 0;
      while (done_cnt == d0 && t < 3000) begin
         step();
         t++;
      end
      if (done_cnt == d0) fail_now("burst_done");
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int a0;
      int d0;
      int t;
      int delivered;
      reset = 1'b1;
      enable = 1'b1;
      freq_word = '0;
      phase_offset = '0;
      cfg_load = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      num_samples = '0;
      repeat (3) step();
      chk("rst_valid", {31'd0, dif.dout_valid}, 32'd0);
      chk("rst_last", {31'd0, dif.dout_last}, 32'd0);
      chk("rst_dout", {16'd0, dif.dout}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      step();

      // Quarter-step sweep over half a turn, including the +1.0 saturation point.
      do_cfg(16'h1000, 16'h0000);
      run_burst(9, 1'b1, 1'b0, 1'b0, '0, '0);

      // Offset-only phases in the third quadrant; second one loads config with start.
      do_cfg(16'h0000, 16'hC000);
      run_burst(1, 1'b0, 1'b0, 1'b0, '0, '0);
      run_burst(1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hB000);

      // Backpressure; cfg_load/start pulses while running must be ignored.
      do_cfg(16'h1000, 16'h0000);
      rdy_mode = 1;
      a0 = accepted;
      run_burst(4, 1'b0, 1'b1, 1'b0, '0, '0);
      chk("stall_accept_count", 32'(accepted - a0), 32'd4);
      rdy_mode = 0;
      step();

      // Continuous mode ended by stop.
      do_cfg(16'h4000, 16'h0000);
      for (int k = 0; k < 64; k++) sb.push_back('{d: model(next_phase()), last: 1'b0});
      a0 = accepted;
      d0 = done_cnt;
      start = 1'b1;
      num_samples = 16'd0;
      step();
      start = 1'b0;
      t = 0;
      while (accepted - a0 < 3 && t < 200) begin
         step();
         t++;
      end
      if (accepted - a0 < 3) fail_now("cont_first_accepts");
      stop = 1'b1;
      step();
      stop = 1'b0;
      t = 0;
      while (done_cnt == d0 && t < 200) begin
         step();
         t++;
      end
      if (done_cnt == d0) fail_now("cont_done");
      delivered = accepted - a0;
      chk("cont_delivered_range", {31'd0, (delivered >= 3 && delivered <= 8)}, 32'd1);
      chk("cont_busy_low", {31'd0, busy}, 32'd0);
      sb.delete();
      step();

      // Accumulator wrap-around with offset.
      do_cfg(16'hF000, 16'h1000);
      run_burst(3, 1'b0, 1'b0, 1'b0, '0, '0);

      // Randomized bursts under random backpressure, sometimes continuing the phase.
      rdy_mode = 2;
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 1) == 1) do_cfg(16'($urandom), 16'($urandom));
         run_burst(int'($urandom_range(1, 12)), 1'b0, 1'b0, 1'b0, '0, '0);
      end

      // Reset in the middle of a stalled burst.
      rdy_mode = 3;
      step();
      step();
      do_cfg(16'h1000, 16'h0000);
      start = 1'b1;
      num_samples = 16'd20;
      step();
      start = 1'b0;
      t = 0;
      while (!dif.dout_valid && t < 20) begin
         step();
         t++;
      end
      if (!dif.dout_valid) fail_now("reset_wait_valid");
      mon_en = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_valid", {31'd0, dif.dout_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("postrst_valid", {31'd0, dif.dout_valid}, 32'd0);
         chk("postrst_done", {31'd0, done}, 32'd0);
         chk("postrst_busy", {31'd0, busy}, 32'd0);
      end

      // enable low mid-burst behaves like reset.
      start = 1'b1;
      num_samples = 16'd5;
      step();
      start = 1'b0;
      repeat (3) step();
      chk("en_busy_before", {31'd0, busy}, 32'd1);
      enable = 1'b0;
      step();
      enable = 1'b1;
      chk("en_off_valid", {31'd0, dif.dout_valid}, 32'd0);
      chk("en_off_busy", {31'd0, busy}, 32'd0);
      step();
      chk("en_off_done", {31'd0, done}, 32'd0);
      sb.delete();
      m_acc = '0;
      m_freq = '0;
      m_off = '0;
      rdy_mode = 0;
      step();
      step();
      mon_en = 1'b1;

      // Restart after reset requires fresh configuration.
      do_cfg(16'h2000, 16'h0800);
      run_burst(5, 1'b1, 1'b0, 1'b0, '0, '0);

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
